// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - dmem_state_e : controller FSM states
//   - DMEM_ADDR_W / DMEM_DEPTH : default RAM word-address width and depth
//   - merge_byte() : place a byte into one lane of a 32-bit word
//   - sext_byte()  : extract one byte lane and sign-extend it to 32 bits
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DEPTH  = 1 << DMEM_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RMW  = 2'd2,
        ST_RESP = 2'd3
    } dmem_state_e;

    // Lane 0 is bits [7:0] (little-endian byte order within the word).
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0: res[7:0]   = data;
            2'd1: res[15:8]  = data;
            2'd2: res[23:16] = data;
            default: res[31:24] = data;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] sext_byte(input logic [31:0] word,
                                              input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            default: b = word[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port 2^ADDR_W x 32 RAM, synchronous write, registered read.
// Ports:
//   clk    : clock
//   we     : write enable (word write of wdata at addr)
//   re     : read enable; rdata updates on the next edge and holds otherwise
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data
// Contents are intentionally not reset so the array maps onto block RAM.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_reg [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store on a valid/ready channel, waits LATENCY cycles,
// then issues a one-cycle rsp_valid pulse. Byte stores are done as
// read-modify-write; byte loads are sign-extended.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_we, req_byte      : store/load, byte/word
//   req_addr, req_wdata   : byte address, store data (byte stores use [7:0])
//   rsp_valid             : one-cycle response pulse
//   rsp_rdata             : registered load data (0 for stores)
//   rsp_err               : misaligned word access flag
// Optional feature: define DMEM_MISALIGN_TRAP_EN to make misaligned word
// accesses respond immediately with rsp_err = 1 and no RAM access.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = DMEM_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    dmem_state_e       state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic              byte_reg, byte_next;
    logic [ADDR_W+1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       word_reg, word_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              err_reg, err_next;

    logic              ram_we, ram_we_raw, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              misalign;

    // Upper address bits are deliberately dropped: addresses wrap modulo the RAM size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = !req_byte && (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        byte_next  = byte_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        word_next  = word_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        ram_re     = 1'b0;
        ram_we_raw = 1'b0;
        ram_addr   = addr_reg[ADDR_W+1:2];
        ram_wdata  = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    we_next    = req_we;
                    byte_next  = req_byte;
                    addr_next  = req_addr[ADDR_W+1:0];
                    wdata_next = req_wdata;
                    if (misalign) begin
                        rdata_next = 32'd0;
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        // Read is issued now so the word is ready long before cnt hits 0.
                        ram_re     = 1'b1;
                        ram_addr   = req_addr[ADDR_W+1:2];
                        cnt_next   = 4'(LATENCY - 1);
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else if (we_reg && !byte_reg) begin
                    ram_we_raw = 1'b1;
                    rdata_next = 32'd0;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if (we_reg) begin
                    word_next  = ram_rdata;
                    state_next = ST_RMW;
                end else begin
                    word_next  = ram_rdata;
                    rdata_next = byte_reg ? sext_byte(ram_rdata, addr_reg[1:0]) : ram_rdata;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end
            end
            ST_RMW: begin
                ram_we_raw = 1'b1;
                ram_wdata  = merge_byte(word_reg, addr_reg[1:0], wdata_reg[7:0]);
                rdata_next = 32'd0;
                err_next   = 1'b0;
                state_next = ST_RESP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A reset on the commit edge must drop the pending write.
    assign ram_we = ram_we_raw && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            byte_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            word_reg  <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            byte_reg  <= byte_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            word_reg  <= word_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl with a word-array reference model.
module tb_dmem_ctrl;

    localparam int L = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    dmem_ctrl #(.LATENCY(L), .ADDR_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference byte-lane helpers, written with shifts and masks.
    function automatic logic [31:0] ref_byte_load(input logic [31:0] w, input int lane);
        logic [31:0] b;
        b = (w >> (8 * lane)) & 32'hFF;
        return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
    endfunction

    function automatic logic [31:0] ref_byte_store(input logic [31:0] w, input int lane,
                                                   input logic [31:0] d);
        return (w & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
    endfunction

    // One complete request: waits for ready, presents it for one cycle,
    // then measures the response latency and checks the response.
    task automatic do_req(input bit we, input bit bt, input logic [31:0] addr,
                          input logic [31:0] wd);
        int          k;
        int          w;
        int          lane;
        int          exp_lat;
        bit          trap;
        logic [31:0] exp_rd;
        w    = int'(addr[11:2]);
        lane = int'(addr[1:0]);
        trap = TRAP && !bt && (lane != 0);
        if (trap) begin
            exp_lat = 1;
            exp_rd  = 32'd0;
        end else if (we) begin
            exp_lat = bt ? L + 2 : L + 1;
            exp_rd  = 32'd0;
            ref_mem[w] = bt ? ref_byte_store(ref_mem[w], lane, wd) : wd;
        end else begin
            exp_lat = L + 1;
            exp_rd  = bt ? ref_byte_load(ref_mem[w], lane) : ref_mem[w];
        end

        k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!rsp_valid) check("ready_busy", 32'(req_ready), 32'd0);
        end while (!rsp_valid && k < 40);
        check("latency", 32'(k), 32'(exp_lat));
        check("ready_resp", 32'(req_ready), 32'd0);
        check("rdata", rsp_rdata, exp_rd);
        check("err", 32'(rsp_err), 32'(trap));
        $display("txn we=%0d byte=%0d addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0d",
                 we, bt, addr, wd, k, rsp_rdata, rsp_err);
    endtask

    initial begin
        int accepts;
        int resps;
        int last_acc;
        logic [31:0] r;
        logic [31:0] widx;
        logic [31:0] lane;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        // Give every word in the exercised window a known value.
        for (int i = 0; i < 128; i++) begin
            do_req(1'b1, 1'b0, 32'(i * 4), $urandom);
        end

        // Directed cases.
        do_req(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
        do_req(1'b0, 1'b0, 32'h40, 32'h0);
        do_req(1'b1, 1'b0, 32'h80, 32'h1122_3344);
        do_req(1'b1, 1'b1, 32'h81, 32'h0000_00AA);
        do_req(1'b0, 1'b0, 32'h80, 32'h0);
        check("rmw_word", rsp_rdata, 32'h1122_AA44);
        do_req(1'b1, 1'b0, 32'h80, 32'h00F0_0000);
        do_req(1'b0, 1'b1, 32'h82, 32'h0);
        check("byte_sext", rsp_rdata, 32'hFFFF_FFF0);
        do_req(1'b1, 1'b0, 32'h42, 32'hCAFE_F00D);
        do_req(1'b0, 1'b0, 32'h40, 32'h0);
        do_req(1'b0, 1'b0, 32'h0000_5040, 32'h0);

        // Continuous req_valid: one acceptance every L+2 cycles.
        do_req(1'b0, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h80;
        accepts   = 0;
        resps     = 0;
        last_acc  = -4;
        for (int c = 0; c < 20; c++) begin
            check("cont_ready", 32'(req_ready), 32'((c % (L + 2)) == 0));
            if (req_ready && req_valid) begin
                check("cont_spacing", 32'(c - last_acc), 32'(L + 2));
                last_acc = c;
                accepts++;
            end
            if (rsp_valid) begin
                resps++;
                check("cont_rdata", rsp_rdata, ref_mem[32]);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) resps++;
            @(negedge clk);
        end
        check("cont_accepts", 32'(accepts), 32'd5);
        check("cont_resps", 32'(resps), 32'd5);
        $display("txn continuous loads: accepts=%0d resps=%0d", accepts, resps);

        // Reset during RMW of a byte store: the write is dropped.
        check("rr_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 32'h101;
        req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            check("rr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rr_rst_ready", 32'(req_ready), 32'd1);
        check("rr_rst_rsp", 32'(rsp_valid), 32'd0);
        check("rr_rst_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rr_after_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("txn byte store 0x101 aborted by reset in RMW");
        do_req(1'b0, 1'b0, 32'h100, 32'h0);

        // Randomized traffic in the initialised window, with aliasing high bits.
        for (int i = 0; i < 200; i++) begin
            r    = $urandom;
            widx = $urandom_range(0, 127);
            lane = $urandom_range(0, 3);
            do_req(r[0], r[1], {r[31:12], 3'b000, widx[6:0], lane[1:0]}, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Multi-cycle data-memory responder that serves the pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It owns the 1024×32 data RAM (word-indexed by address bits [11:2]) and models a configurable access latency so the pipeline can be exercised against stalling memory. Sub-word stores are implemented as read-modify-write; byte loads are sign-extended.

## Interface
Parameters:
- LATENCY, 2: wait cycles per access, legal range 1..15
- ADDR_W, 10: RAM word-address width, giving 2^ADDR_W words

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_byte  input  1  1 = byte access, 0 = word access
- req_addr  input  32  byte address
- req_wdata  input  32  store data; bits [7:0] are used for byte stores
- rsp_valid  output  1  one-cycle response pulse, issued for loads and stores
- rsp_rdata  output  32  load data, valid while rsp_valid is high
- rsp_err  output  1  misaligned-access flag (see Configuration)

## Operation
- States: IDLE, WAIT, RMW, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, latch we, byte, addr and wdata, load cnt = LATENCY-1, and go to WAIT.
  - Issue a RAM read of addr[ADDR_W+1:2].
- WAIT:
  - req_ready = 0.
  - While cnt != 0, decrement cnt.
  - When cnt == 0:
    - Word store: write the RAM and go to RESP.
    - Byte store: capture the RAM word and go to RMW.
    - Load: capture the RAM word and go to RESP.
- RMW:
  - Merge wdata[7:0] into byte lane addr[1:0] (lane 0 = bits [7:0]).
  - Write the merged word and go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata = captured word for a word load, or the sign-extended lane byte for a byte load; 0 for stores.
  - Go to IDLE.
- Requests presented while req_ready = 0 are ignored; the requester holds them.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4 KiB.
- For word accesses, addr[1:0] are ignored (when the trap is compiled out).
- RAM contents are not cleared by reset.

## Timing
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cnt = 0.
- Request accepted in cycle 0:
  - Word access: rsp_valid in cycle LATENCY+1, req_ready high again in cycle LATENCY+2.
  - Byte store: one cycle more than a word access.
- Back-to-back throughput is one request per LATENCY+2 cycles (word access).
- Memory write commit points:
  - Word store: the edge leaving WAIT.
  - Byte store: the edge leaving RMW.
- Reset mid-operation:
  - Reset asserted before the commit edge: the write is dropped and RAM is unchanged.
  - In all cases the FSM returns to IDLE and no response is issued.
- rsp_rdata is registered and holds its value until the next RESP.
- A load following a store to the same word returns the stored data, because the store commits before its RESP.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A word access with addr[1:0] != 0 is accepted, but there is no RAM access and no write.
  - The FSM goes IDLE→RESP directly, so rsp_valid appears in cycle 1 with rsp_err = 1 and rsp_rdata = 0.
  - Byte accesses never trap.
- DMEM_MISALIGN_TRAP_EN undefined:
  - rsp_err is tied to 0.
  - Word accesses use addr[1:0] = 00 implicitly.

## Structure
- Package dmem_pkg holds:
  - The state enum (IDLE/WAIT/RMW/RESP).
  - The byte-lane merge and sign-extend functions.
  - The RAM depth constant.
- Sub-module dmem_ram: single-port RAM of 2^ADDR_W × 32, with synchronous write and registered read, instantiated once.

## Test plan
- Reset, then a word store of 0xDEADBEEF to 0x40 followed by a word load from 0x40 -> load returns rsp_valid in cycle 3 with rsp_rdata = 0xDEADBEEF; the store's rsp_valid is in cycle 3 of its own request (LATENCY = 2).
- Word store of 0x11223344 to 0x80, byte store of 0xAA to 0x81, then a word load from 0x80 -> 0x1122AA44; the byte store's rsp_valid appears one cycle later than a word store's.
- Byte load from 0x82 after storing 0x00F00000 at 0x80 -> rsp_rdata = 0xFFFFFFF0.
- req_valid held high continuously -> exactly one acceptance per 4 cycles, and req_ready is 0 during WAIT and RESP.
- Byte store to 0x100 with reset asserted during RMW -> no response, and a later load from 0x100 returns the old word.
- With DMEM_MISALIGN_TRAP_EN defined, a word store to 0x42 -> rsp_valid in cycle 1 with rsp_err = 1, and word 0x40 is unchanged; without the macro, the same store writes word 0x40.
